// File: rtl/mem_reg_file.sv
// mem_reg_file: byte-enabled register file with a self-clearing start-up sequence.
// After reset, every entry is written with pCLR_VALUE, one entry per clock, while or_busy is high.
// Reads take one cycle by default. Defining MEM_REG_FILE_OUT_REG_EN adds an output register,
// which makes the read latency two cycles.
module mem_reg_file #(
    parameter int                     pDATA_WIDTH = 32,
    parameter int                     pDEPTH_RAM  = 64,
    parameter logic [pDATA_WIDTH-1:0] pCLR_VALUE  = '0
) (
    input  logic                          iclk,
    input  logic                          irst,
    input  logic                          iwr_en,
    input  logic [$clog2(pDEPTH_RAM)-1:0] iw_addr,
    input  logic [pDATA_WIDTH-1:0]        iw_reg_data,
    input  logic [pDATA_WIDTH/8-1:0]      iw_be,
    input  logic                          ird_en,
    input  logic [$clog2(pDEPTH_RAM)-1:0] ir_addr,
    output logic [pDATA_WIDTH-1:0]        or_data,
    output logic                          or_valid,
    output logic                          or_busy
);

    localparam int             AW        = $clog2(pDEPTH_RAM);
    localparam int             NB        = pDATA_WIDTH / 8;
    localparam logic [AW:0]    DEPTH_V   = (AW + 1)'(pDEPTH_RAM);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(pDEPTH_RAM - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [AW-1:0]           clr_cnt;
    logic [AW-1:0]           clr_cnt_next;
    logic                    clr_fire;
    logic                    wr_fire;
    logic                    rd_fire;

    logic [pDATA_WIDTH-1:0]  mem [pDEPTH_RAM];

    logic [pDATA_WIDTH-1:0]  data_p0;
    logic                    vld_p0;

    // Addresses past the last entry are decoded but never touch the array.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return {1'b0, addr} < DEPTH_V;
    endfunction

    // State register and clear counter; reset always restarts the clear from entry 0.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Next-state logic and per-cycle strobes; user requests are accepted only in READY.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        clr_fire     = 1'b0;
        wr_fire      = 1'b0;
        rd_fire      = 1'b0;
        or_busy      = 1'b0;
        case (state)
            ST_CLEAR: begin
                or_busy      = 1'b1;
                clr_fire     = !irst;
                clr_cnt_next = clr_cnt + 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_next   = ST_READY;
                    clr_cnt_next = '0;
                end
            end
            ST_READY: begin
                wr_fire = iwr_en && !irst && in_range(iw_addr);
                rd_fire = ird_en && !irst;
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    // Array write port: the clear sequence has priority, otherwise byte-lane masked user writes.
    always_ff @(posedge iclk) begin
        if (clr_fire) begin
            mem[clr_cnt] <= pCLR_VALUE;
        end else if (wr_fire) begin
            for (int k = 0; k < NB; k++) begin
                if (iw_be[k]) begin
                    mem[iw_addr][8*k +: 8] <= iw_reg_data[8*k +: 8];
                end
            end
        end
    end

    // Read stage p0: array lookup (old contents on a same-cycle write), data holds when idle.
    always_ff @(posedge iclk) begin
        if (irst) begin
            data_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= rd_fire;
            if (rd_fire) begin
                data_p0 <= in_range(ir_addr) ? mem[ir_addr] : '0;
            end
        end
    end

`ifdef MEM_REG_FILE_OUT_REG_EN
    logic [pDATA_WIDTH-1:0]  data_p1;
    logic                    vld_p1;

    // Read stage p1: optional output register, flushed by reset together with p0.
    always_ff @(posedge iclk) begin
        if (irst) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                data_p1 <= data_p0;
            end
        end
    end

    assign or_data  = data_p1;
    assign or_valid = vld_p1;
`else
    assign or_data  = data_p0;
    assign or_valid = vld_p0;
`endif

endmodule

// File: tb/tb_mem_reg_file.sv
// tb_mem_reg_file: scoreboard bench for mem_reg_file.
// Instance 0 has 64 entries and clears to 0xDEADBEEF. Instance 1 has 48 entries and clears to
// 0x5A5A5A5A, which leaves room to exercise out-of-range addresses.
module tb_mem_reg_file;

    localparam logic [31:0] CLR_A = 32'hDEADBEEF;
    localparam logic [31:0] CLR_B = 32'h5A5A5A5A;
`ifdef MEM_REG_FILE_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        rst   [2];
    logic        wr    [2];
    logic        rd    [2];
    logic [5:0]  waddr [2];
    logic [5:0]  raddr [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic [31:0] odata [2];
    logic        ovld  [2];
    logic        obusy [2];

    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    int          cyc_q0 [$];
    int          cyc_q1 [$];

    int checks = 0;
    int errors = 0;

    mem_reg_file #(.pDATA_WIDTH(32), .pDEPTH_RAM(64), .pCLR_VALUE(CLR_A)) dut_a (
        .iclk(clk), .irst(rst[0]), .iwr_en(wr[0]), .iw_addr(waddr[0]),
        .iw_reg_data(wdata[0]), .iw_be(be[0]), .ird_en(rd[0]), .ir_addr(raddr[0]),
        .or_data(odata[0]), .or_valid(ovld[0]), .or_busy(obusy[0])
    );

    mem_reg_file #(.pDATA_WIDTH(32), .pDEPTH_RAM(48), .pCLR_VALUE(CLR_B)) dut_b (
        .iclk(clk), .irst(rst[1]), .iwr_en(wr[1]), .iw_addr(waddr[1]),
        .iw_reg_data(wdata[1]), .iw_be(be[1]), .ird_en(rd[1]), .ir_addr(raddr[1]),
        .or_data(odata[1]), .or_valid(ovld[1]), .or_busy(obusy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every or_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        int          c;
        if (ovld[0]) begin
            if (exp_q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_valid actual=%h required=no pulse", odata[0]);
            end else begin
                e = exp_q0.pop_front();
                c = cyc_q0.pop_front();
                chk("a_rd_data", odata[0], e);
                chk("a_rd_latency", 32'(cyc - c), 32'(LAT));
            end
        end
        if (ovld[1]) begin
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_valid actual=%h required=no pulse", odata[1]);
            end else begin
                e = exp_q1.pop_front();
                c = cyc_q1.pop_front();
                chk("b_rd_data", odata[1], e);
                chk("b_rd_latency", 32'(cyc - c), 32'(LAT));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One clock of stimulus; a read pushes its expected word and issue cycle.
    task automatic op(input int s, input bit w, input logic [5:0] wa, input logic [31:0] wd,
                      input logic [3:0] b, input bit r, input logic [5:0] ra, input logic [31:0] e);
        wr[s]    = w;
        waddr[s] = wa;
        wdata[s] = wd;
        be[s]    = b;
        rd[s]    = r;
        raddr[s] = ra;
        if (r) begin
            if (s == 0) begin
                exp_q0.push_back(e);
                cyc_q0.push_back(cyc);
            end else begin
                exp_q1.push_back(e);
                cyc_q1.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        wr[s] = 1'b0;
        rd[s] = 1'b0;
    endtask

    task automatic wr_op(input int s, input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
        op(s, 1'b1, a, d, b, 1'b0, 6'd0, 32'h0);
    endtask

    task automatic rd_op(input int s, input logic [5:0] a, input logic [31:0] e);
        op(s, 1'b0, 6'd0, 32'h0, 4'h0, 1'b1, a, e);
    endtask

    // One-cycle reset, reset-state check, then count the busy cycles (bounded).
    task automatic reset_and_count(input int s, input int depth);
        int n;
        rst[s] = 1'b1;
        @(posedge clk);
        #1;
        rst[s] = 1'b0;
        chk("rst_busy", 32'(obusy[s]), 32'd1);
        chk("rst_valid", 32'(ovld[s]), 32'd0);
        chk("rst_data", odata[s], 32'h0);
        n = 0;
        while (obusy[s] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("busy_cycles", 32'(n), 32'(depth));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; wr[s] = 1'b0; rd[s] = 1'b0;
            waddr[s] = '0; raddr[s] = '0; wdata[s] = '0; be[s] = '0;
        end
        idle(2);

        // Instance 0: the clear takes 64 cycles, then every entry reads back as the clear value.
        reset_and_count(0, 64);
        for (int i = 0; i < 64; i++) rd_op(0, 6'(i), CLR_A);
        idle(LAT + 2);

        // Byte enables: AABBCCDD then 11223344 with lanes 0 and 2 gives AA22CC44; be=0 is a no-op.
        wr_op(0, 6'd5, 32'hAABBCCDD, 4'b1111);
        wr_op(0, 6'd5, 32'h11223344, 4'b0101);
        rd_op(0, 6'd5, 32'hAA22CC44);
        wr_op(0, 6'd5, 32'hFFFFFFFF, 4'b0000);
        rd_op(0, 6'd5, 32'hAA22CC44);

        // Collision: a same-cycle read sees the old word, and the next read sees the new one.
        wr_op(0, 6'd3, 32'h00000000, 4'b1111);
        op(0, 1'b1, 6'd3, 32'h12345678, 4'b1111, 1'b1, 6'd3, 32'h00000000);
        rd_op(0, 6'd3, 32'h12345678);

        // Streaming: 8 back-to-back reads of freshly written words.
        for (int i = 0; i < 8; i++) wr_op(0, 6'(i), 32'hC0DE0000 | 32'(i), 4'b1111);
        for (int i = 0; i < 8; i++) rd_op(0, 6'(i), 32'hC0DE0000 | 32'(i));
        idle(LAT + 2);
        chk("a_hold_data", odata[0], 32'hC0DE0007);
        chk("a_hold_valid", 32'(ovld[0]), 32'd0);

        // A reset in READY aborts a simultaneous read. Requests during the clear are ignored,
        // and a reset at counter 20 restarts the full clear.
        rd[0] = 1'b1; raddr[0] = 6'd7;
        wr[0] = 1'b1; waddr[0] = 6'd10; wdata[0] = 32'h0BADF00D; be[0] = 4'b1111;
        reset_and_count(0, 64);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        idle(20);
        chk("a_busy_at_20", 32'(obusy[0]), 32'd1);
        reset_and_count(0, 64);
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        rd_op(0, 6'd10, CLR_A);
        rd_op(0, 6'd0, CLR_A);
        rd_op(0, 6'd63, CLR_A);
        idle(LAT + 2);

        // Instance 1 (48 entries): out-of-range writes are dropped and out-of-range reads return zero.
        reset_and_count(1, 48);
        wr_op(1, 6'd50, 32'hFFFFFFFF, 4'b1111);
        rd_op(1, 6'd50, 32'h00000000);
        for (int i = 0; i < 48; i++) rd_op(1, 6'(i), CLR_B);
        rd_op(1, 6'd63, 32'h00000000);
        idle(LAT + 3);

        chk("a_queue_empty", 32'(exp_q0.size()), 32'd0);
        chk("b_queue_empty", 32'(exp_q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_reg_file.md
MEM_REG_FILE -- requirements
Module: mem_reg_file

Interface
REQ-001 The block SHALL have parameter pDATA_WIDTH, default 32, word width in bits, which SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter pDEPTH_RAM, default 64, number of words, any value >= 2 (non-power-of-2 allowed).
REQ-003 The block SHALL have parameter pCLR_VALUE, default 0, pDATA_WIDTH-bit word written to every entry by the clear sequence.
REQ-004 The block SHALL have port iclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port irst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port iwr_en, input, 1 bit: write request.
REQ-007 The block SHALL have port iw_addr, input, $clog2(pDEPTH_RAM) bits: write address.
REQ-008 The block SHALL have port iw_reg_data, input, pDATA_WIDTH bits: write data.
REQ-009 The block SHALL have port iw_be, input, pDATA_WIDTH/8 bits: byte enables; bit k controls data bits [8k+7:8k].
REQ-010 The block SHALL have port ird_en, input, 1 bit: read request.
REQ-011 The block SHALL have port ir_addr, input, $clog2(pDEPTH_RAM) bits: read address.
REQ-012 The block SHALL have port or_data, output reg, pDATA_WIDTH bits: read data.
REQ-013 The block SHALL have port or_valid, output reg, 1 bit: one-cycle pulse marking or_data as the result of a read.
REQ-014 The block SHALL have port or_busy, output reg, 1 bit: high while the clear sequence runs.

Function
REQ-015 The block SHALL implement a two-state FSM: CLEAR and READY.
REQ-016 CLEAR SHALL write pCLR_VALUE to the entry at clear counter, counter 0..pDEPTH_RAM-1, one entry per cycle.
REQ-017 After writing entry pDEPTH_RAM-1, CLEAR SHALL go to READY on the next edge; or_busy SHALL fall in that cycle, exactly pDEPTH_RAM cycles after irst deasserts.
REQ-018 While in CLEAR, iwr_en and ird_en SHALL be ignored (no write, no or_valid pulse).
REQ-019 In READY, iwr_en=1 SHALL update only the byte lanes of entry iw_addr whose iw_be bit is 1; other lanes keep their value; iw_be=0 leaves the entry unchanged.
REQ-020 In READY, ird_en=1 SHALL present entry ir_addr on or_data with or_valid=1 exactly one cycle later (base latency 1).
REQ-021 When no read completes, or_valid SHALL be 0 and or_data SHALL hold its last value.
REQ-022 Read and write of the same address in the same cycle SHALL return the old (pre-write) contents; the write takes effect for later reads.
REQ-023 Back-to-back reads on every cycle SHALL each produce one or_valid pulse, in order, with no bubbles.
REQ-024 An address >= pDEPTH_RAM SHALL make the write a no-op; a read of such an address SHALL return all zeros with or_valid=1.

Reset
REQ-025 On irst=1 at a clock edge, the block SHALL enter CLEAR with clear counter=0, or_busy=1, or_valid=0, or_data=0.
REQ-026 irst asserted mid-clear SHALL restart clearing from entry 0; irst asserted in READY SHALL abort any in-flight read (no or_valid pulse) and re-clear the full array.
REQ-027 Array contents SHALL not be reset directly; they SHALL be defined only through the clear sequence.

Configuration
REQ-028 Macro MEM_REG_FILE_OUT_REG_EN SHALL control an extra output register stage.
REQ-029 When MEM_REG_FILE_OUT_REG_EN is defined, read latency SHALL be 2 cycles, with or_valid delayed to match or_data; the extra stage SHALL reset to 0 and be flushed by irst.
REQ-030 When MEM_REG_FILE_OUT_REG_EN is undefined, read latency SHALL be 1 cycle per REQ-020.
REQ-031 All other behaviour SHALL be identical with and without the macro.

Verification
REQ-032 The bench SHALL cover clear: pDEPTH_RAM=64 with irst for 1 cycle -> or_busy=1 for exactly 64 cycles, then a read of each address returns pCLR_VALUE.
REQ-033 The bench SHALL cover byte enables: write 0xAABBCCDD to addr 5 with iw_be=4'b1111, then 0x11223344 with iw_be=4'b0101 -> read of addr 5 returns 0xAA22CC44.
REQ-034 The bench SHALL cover collision: addr 3 holds 0x0; same-cycle write 0x12345678 and read of addr 3 -> 0x00000000 returned; next read returns 0x12345678.
REQ-035 The bench SHALL cover streaming: reads of addr 0..7 on 8 consecutive cycles -> 8 consecutive or_valid pulses at latency 1 (2 with MEM_REG_FILE_OUT_REG_EN) with data in order.
REQ-036 The bench SHALL cover reset mid-clear: irst reasserted at clear counter=20 -> clearing restarts at 0, or_busy stays high 64 further cycles, no or_valid pulse.
REQ-037 The bench SHALL cover out-of-range access: pDEPTH_RAM=48, write to addr 50, then read addr 50 -> or_data=0 with or_valid=1, and entries 0..47 unchanged.
